// File: rtl/trace_capture.sv
// trace_capture: samples channel/control bundles with a tick stamp into a circular trace buffer drained via valid/ready
module trace_capture #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 6,
    parameter int CTRL_W   = 14,
    parameter int DEPTH    = 16,
    parameter int TICK_W   = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      arm,
    input  logic [TICK_W-1:0]                         step_limit,
    input  logic                                      change_only,
    input  logic                                      wrap_mode,
    input  logic                                      sample_en,
    input  logic [CHANNELS*WIDTH-1:0]                 chan_in,
    input  logic [CTRL_W-1:0]                         ctrl_in,
    input  logic                                      rd_ready,
    output logic                                      rd_valid,
    output logic [TICK_W+CTRL_W+CHANNELS*WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]                count,
    output logic                                      overflow,
    output logic                                      busy,
    output logic                                      done,
    output logic [TICK_W-1:0]                         ticks
);
    localparam int PW = CTRL_W + CHANNELS * WIDTH;
    localparam int EW = TICK_W + PW;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;

    logic [1:0]        state;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [PW-1:0]     payload, last;
    logic              have_last, capturing, push, pop, full, wr, limit_hit;
    logic [TICK_W:0]   tick_next;

    // Record decision, buffer handshake and end-of-capture detection
    always_comb begin
        payload   = {ctrl_in, chan_in};
        capturing = state == CAPTURE;
        push      = capturing && !arm && sample_en && (!change_only || !have_last || payload != last);
        pop       = rd_valid && rd_ready && !arm;
        full      = count == CW'(DEPTH);
        wr        = push && (pop || !full || wrap_mode);
        tick_next = {1'b0, ticks} + (TICK_W+1)'(1);
        limit_hit = step_limit != '0 && tick_next >= {1'b0, step_limit};
    end

    assign rd_valid = count != '0;
    assign rd_data  = mem[rp];
    assign busy     = capturing;
    assign done     = state == DONE;

    // Capture FSM, tick counter and the last-recorded comparison register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            ticks     <= '0;
            have_last <= 1'b0;
            last      <= '0;
        end else if (arm) begin
            state     <= CAPTURE;
            ticks     <= '0;
            have_last <= 1'b0;
        end else if (capturing) begin
            ticks <= tick_next[TICK_W-1:0];
            if (limit_hit)
                state <= DONE;
            if (push) begin
                have_last <= 1'b1;
                last      <= payload;
            end
        end
    end

    // Pointers, occupancy and sticky overflow; a push into a full buffer with a pop is lossless
    always_ff @(posedge clk) begin
        if (!reset_n || arm) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wp <= wp + AW'(1);
            if (pop || (push && full && wrap_mode))
                rp <= rp + AW'(1);
            if (push && !pop && !full)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    // Entry storage; the stamp is the tick value of the sampled cycle
    always_ff @(posedge clk) begin
        if (reset_n && wr)
            mem[wp] <= {ticks, payload};
    end
endmodule
